// File: rtl/y_update_diag_seq.sv
// Diagonal-update sequencer: issues one diagonal op, then N add/sub term ops,
// to a downstream accumulator stage, and captures the final sum once it drains.
module y_update_diag_seq #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic [WIDTH-1:0] diag_in,
  input  logic             term_valid,
  output logic             term_ready,
  input  logic [WIDTH-1:0] term_in,
  input  logic             term_is_old,
  input  logic             term_sub,
  output logic [WIDTH-1:0] y_diag,
  output logic [WIDTH-1:0] y_old,
  output logic [WIDTH-1:0] y_new,
  output logic             sel_diag_or_sum,
  output logic [1:0]       sel_old_or_new,
  output logic             sel_mode_addsub,
  input  logic [WIDTH-1:0] result_in,
  output logic [WIDTH-1:0] result_out,
  output logic             result_valid,
  output logic             busy
);

  localparam logic [1:0] SEL_NEW  = 2'b00;
  localparam logic [1:0] SEL_OLD  = 2'b11;
  localparam logic [1:0] SEL_ZERO = 2'b01;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
  logic [1:0]       r_drain_cnt;
  logic             w_issue_diag, w_issue_term, w_drain_last;

  logic [WIDTH-1:0] r_y_diag, r_y_old, r_y_new, r_result_out;

  logic             r_vld_p0, r_diag_p0, r_old_p0, r_sub_p0;
  logic             r_sel_sum_p1, r_sel_mode_p1;
  logic [1:0]       r_sel_on_p1;

  assign w_issue_diag = (r_state == IDLE) && start;
  assign w_issue_term = (r_state == ACC) && term_valid;
  assign w_drain_last = (r_state == DRAIN) && (r_drain_cnt == 2'd2);

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_remaining_nxt = num_terms;
          w_state_nxt     = (num_terms != '0) ? ACC : DRAIN;
        end
      end
      ACC: begin
        if (term_valid) begin
          w_remaining_nxt = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == 2'd2) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The drain counter restarts every time DRAIN is entered; two edges of
  // pipeline latency follow the last op, the third edge captures the sum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
    end
  end

  // Stage p0: operand registers and the op issued this edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_y_diag  <= '0;
      r_y_old   <= '0;
      r_y_new   <= '0;
      r_vld_p0  <= 1'b0;
      r_diag_p0 <= 1'b0;
      r_old_p0  <= 1'b0;
      r_sub_p0  <= 1'b0;
    end else begin
      r_vld_p0  <= w_issue_diag || w_issue_term;
      r_diag_p0 <= w_issue_diag;
      r_old_p0  <= w_issue_term && term_is_old;
      r_sub_p0  <= w_issue_term && term_sub;
      if (w_issue_diag) r_y_diag <= diag_in;
      if (w_issue_term && term_is_old)  r_y_old <= term_in;
      if (w_issue_term && !term_is_old) r_y_new <= term_in;
    end
  end

  // Stage p1: selects trail the operands by one edge; hold code adds zero to the sum
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sel_sum_p1  <= 1'b1;
      r_sel_on_p1   <= SEL_ZERO;
      r_sel_mode_p1 <= 1'b0;
    end else if (!r_vld_p0) begin
      r_sel_sum_p1  <= 1'b1;
      r_sel_on_p1   <= SEL_ZERO;
      r_sel_mode_p1 <= 1'b0;
    end else if (r_diag_p0) begin
      r_sel_sum_p1  <= 1'b0;
      r_sel_on_p1   <= SEL_ZERO;
      r_sel_mode_p1 <= 1'b0;
    end else begin
      r_sel_sum_p1  <= 1'b1;
      r_sel_on_p1   <= r_old_p0 ? SEL_OLD : SEL_NEW;
      r_sel_mode_p1 <= r_sub_p0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)            r_result_out <= '0;
    else if (w_drain_last) r_result_out <= result_in;
  end

  assign y_diag          = r_y_diag;
  assign y_old           = r_y_old;
  assign y_new           = r_y_new;
  assign sel_diag_or_sum = r_sel_sum_p1;
  assign sel_old_or_new  = r_sel_on_p1;
  assign sel_mode_addsub = r_sel_mode_p1;
  assign result_out      = r_result_out;
  assign result_valid    = (r_state == DONE);
  assign term_ready      = (r_state == ACC);
  assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_y_update_diag_seq.sv
// Directed bench for y_update_diag_seq, paired with a behavioural model of the
// downstream add/sub stage (input registers, adder, output register).
module tb_y_update_diag_seq;
  localparam int W = 48;
  localparam int C = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [C-1:0] num_terms;
  logic [W-1:0] diag_in, term_in;
  logic         term_valid, term_is_old, term_sub;
  logic         term_ready;
  logic [W-1:0] y_diag, y_old, y_new, result_in, result_out;
  logic         sel_diag_or_sum, sel_mode_addsub, result_valid, busy;
  logic [1:0]   sel_old_or_new;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  y_update_diag_seq #(.WIDTH(W), .CNT_W(C)) dut (
    .clock(clock), .reset(reset), .start(start), .num_terms(num_terms),
    .diag_in(diag_in), .term_valid(term_valid), .term_ready(term_ready),
    .term_in(term_in), .term_is_old(term_is_old), .term_sub(term_sub),
    .y_diag(y_diag), .y_old(y_old), .y_new(y_new),
    .sel_diag_or_sum(sel_diag_or_sum), .sel_old_or_new(sel_old_or_new),
    .sel_mode_addsub(sel_mode_addsub), .result_in(result_in),
    .result_out(result_out), .result_valid(result_valid), .busy(busy)
  );

  // Downstream stage model
  logic [W-1:0] m_diag, m_old, m_new, m_sum, m_in1, m_in2, m_out;
  always_comb begin
    m_in1 = sel_diag_or_sum ? m_sum : m_diag;
    case (sel_old_or_new)
      2'b11:   m_in2 = m_old;
      2'b00:   m_in2 = m_new;
      default: m_in2 = '0;
    endcase
    m_out = sel_mode_addsub ? (m_in1 - m_in2) : (m_in1 + m_in2);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_diag <= '0; m_old <= '0; m_new <= '0; m_sum <= '0;
    end else begin
      m_diag <= y_diag; m_old <= y_old; m_new <= y_new; m_sum <= m_out;
    end
  end
  assign result_in = m_sum;

  logic [3:0] sel;
  assign sel = {sel_diag_or_sum, sel_old_or_new, sel_mode_addsub};
  localparam logic [3:0] S_HOLD = 4'b1010, S_DIAG = 4'b0010;
  localparam logic [3:0] S_NEW_ADD = 4'b1000, S_OLD_SUB = 4'b1111, S_OLD_ADD = 4'b1110;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; num_terms = '0; diag_in = '0; term_valid = 0;
    term_in = '0; term_is_old = 0; term_sub = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    tick(); tick();
    n_tests++; if (busy !== 1'b0 || term_ready !== 1'b0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got busy=%b ready=%b rv=%b want 0/0/0", busy, term_ready, result_valid); end
    n_tests++; if (y_diag !== '0 || y_old !== '0 || y_new !== '0 || result_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h want all 0", y_diag, y_old, y_new, result_out); end
    n_tests++; if (sel !== S_HOLD) begin n_fail++; $display("FAIL reset_sel: got %b want %b", sel, S_HOLD); end
    reset = 1;
    tick();
  endtask

  task automatic test_zero_terms();
    start = 1; num_terms = 0; diag_in = 48'h000000_000005;
    tick(); // start edge
    start = 0;
    n_tests++; if (busy !== 1'b1 || y_diag !== 48'h5 || term_ready !== 1'b0) begin n_fail++; $display("FAIL zero_issue: got busy=%b y_diag=%h ready=%b want 1/5/0", busy, y_diag, term_ready); end
    tick();
    n_tests++; if (sel !== S_DIAG) begin n_fail++; $display("FAIL zero_sel_diag: got %b want %b", sel, S_DIAG); end
    tick();
    n_tests++; if (sel !== S_HOLD || result_valid !== 1'b0) begin n_fail++; $display("FAIL zero_drain: got sel=%b rv=%b want %b/0", sel, result_valid, S_HOLD); end
    tick();
    n_tests++; if (result_valid !== 1'b1 || result_out !== 48'h5) begin n_fail++; $display("FAIL zero_result: got rv=%b out=%h want 1/5", result_valid, result_out); end
    tick();
    n_tests++; if (result_valid !== 1'b0 || busy !== 1'b0 || result_out !== 48'h5) begin n_fail++; $display("FAIL zero_after: got rv=%b busy=%b out=%h want 0/0/5", result_valid, busy, result_out); end
  endtask

  task automatic test_back_to_back();
    start = 1; num_terms = 3; diag_in = 48'h10;
    tick(); // E0
    start = 0; term_valid = 1; term_in = 48'h4; term_is_old = 0; term_sub = 0;
    tick(); // E1
    n_tests++; if (y_new !== 48'h4 || term_ready !== 1'b1 || sel !== S_DIAG) begin n_fail++; $display("FAIL b2b_e1: got y_new=%h ready=%b sel=%b want 4/1/%b", y_new, term_ready, sel, S_DIAG); end
    term_in = 48'h1; term_is_old = 1; term_sub = 1;
    tick(); // E2
    n_tests++; if (y_old !== 48'h1 || y_new !== 48'h4 || sel !== S_NEW_ADD) begin n_fail++; $display("FAIL b2b_e2: got y_old=%h y_new=%h sel=%b want 1/4/%b", y_old, y_new, sel, S_NEW_ADD); end
    term_in = 48'h2; term_is_old = 0; term_sub = 0;
    tick(); // E3
    term_valid = 0;
    n_tests++; if (y_new !== 48'h2 || y_old !== 48'h1 || sel !== S_OLD_SUB || term_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_e3: got y_new=%h y_old=%h sel=%b ready=%b want 2/1/%b/0", y_new, y_old, sel, term_ready, S_OLD_SUB); end
    tick(); // E4
    n_tests++; if (sel !== S_NEW_ADD || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_e4: got sel=%b busy=%b want %b/1", sel, busy, S_NEW_ADD); end
    tick(); // E5
    n_tests++; if (sel !== S_HOLD || result_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_e5: got sel=%b rv=%b want %b/0", sel, result_valid, S_HOLD); end
    tick(); // E6
    n_tests++; if (result_valid !== 1'b1 || result_out !== 48'h15) begin n_fail++; $display("FAIL b2b_result: got rv=%b out=%h want 1/15", result_valid, result_out); end
    tick();
    n_tests++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got rv=%b busy=%b want 0/0", result_valid, busy); end
  endtask

  task automatic test_stall();
    start = 1; num_terms = 3; diag_in = 48'h10;
    tick(); // E0
    start = 0; term_valid = 1; term_in = 48'h4; term_is_old = 0; term_sub = 0;
    tick(); // E1
    term_valid = 0;
    tick(); // E2
    n_tests++; if (sel !== S_NEW_ADD) begin n_fail++; $display("FAIL stall_e2: got sel=%b want %b", sel, S_NEW_ADD); end
    tick(); // E3
    n_tests++; if (sel !== S_HOLD || term_ready !== 1'b1) begin n_fail++; $display("FAIL stall_e3: got sel=%b ready=%b want %b/1", sel, term_ready, S_HOLD); end
    term_valid = 1; term_in = 48'h1; term_is_old = 1; term_sub = 1;
    tick(); // E4
    n_tests++; if (sel !== S_HOLD || y_old !== 48'h1) begin n_fail++; $display("FAIL stall_e4: got sel=%b y_old=%h want %b/1", sel, y_old, S_HOLD); end
    term_in = 48'h2; term_is_old = 0; term_sub = 0;
    tick(); // E5
    term_valid = 0;
    n_tests++; if (sel !== S_OLD_SUB) begin n_fail++; $display("FAIL stall_e5: got sel=%b want %b", sel, S_OLD_SUB); end
    tick(); // E6
    n_tests++; if (sel !== S_NEW_ADD) begin n_fail++; $display("FAIL stall_e6: got sel=%b want %b", sel, S_NEW_ADD); end
    tick(); // E7
    n_tests++; if (sel !== S_HOLD || result_valid !== 1'b0) begin n_fail++; $display("FAIL stall_e7: got sel=%b rv=%b want %b/0", sel, result_valid, S_HOLD); end
    tick(); // E8
    n_tests++; if (result_valid !== 1'b1 || result_out !== 48'h15) begin n_fail++; $display("FAIL stall_result: got rv=%b out=%h want 1/15", result_valid, result_out); end
    tick();
  endtask

  task automatic test_start_ignored();
    int rv_cnt = 0;
    start = 1; num_terms = 2; diag_in = 48'h20;
    tick(); // E0
    start = 1; num_terms = 0; diag_in = 48'h99; term_valid = 0;
    tick(); // E1: start seen in ACC
    n_tests++; if (busy !== 1'b1 || term_ready !== 1'b1 || y_diag !== 48'h20) begin n_fail++; $display("FAIL ign_acc: got busy=%b ready=%b y_diag=%h want 1/1/20", busy, term_ready, y_diag); end
    term_valid = 1; term_in = 48'h3; term_is_old = 0; term_sub = 0;
    tick(); // E2
    term_in = 48'h5; term_is_old = 1; term_sub = 0;
    tick(); // E3 -> DRAIN
    term_valid = 0;
    for (int k = 4; k <= 6; k++) begin
      if (result_valid) rv_cnt++;
      n_tests++; if (busy !== 1'b1 || y_diag !== 48'h20) begin n_fail++; $display("FAIL ign_drain_e%0d: got busy=%b y_diag=%h want 1/20", k - 1, busy, y_diag); end
      tick();
    end
    n_tests++; if (result_valid !== 1'b1 || result_out !== 48'h28) begin n_fail++; $display("FAIL ign_result: got rv=%b out=%h want 1/28", result_valid, result_out); end
    if (result_valid) rv_cnt++;
    tick(); // E7: IDLE, start still high
    if (result_valid) rv_cnt++;
    n_tests++; if (rv_cnt !== 1) begin n_fail++; $display("FAIL ign_rv_count: got %0d want 1", rv_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got busy=%b want 0", busy); end
    tick(); // E8: accepted
    start = 0;
    n_tests++; if (busy !== 1'b1 || y_diag !== 48'h99) begin n_fail++; $display("FAIL ign_restart: got busy=%b y_diag=%h want 1/99", busy, y_diag); end
    tick(); tick(); tick();
    n_tests++; if (result_valid !== 1'b1 || result_out !== 48'h99) begin n_fail++; $display("FAIL ign_second: got rv=%b out=%h want 1/99", result_valid, result_out); end
    tick();
  endtask

  task automatic test_reset_abort();
    int rv_cnt = 0;
    start = 1; num_terms = 3; diag_in = 48'h10;
    tick(); // E0
    start = 0; term_valid = 1; term_in = 48'h4; term_is_old = 0; term_sub = 0;
    tick(); // E1: one term accepted
    idle_inputs();
    reset = 0;
    tick();
    n_tests++; if (busy !== 1'b0 || term_ready !== 1'b0 || result_valid !== 1'b0 || sel !== S_HOLD) begin n_fail++; $display("FAIL abort_ctrl: got busy=%b ready=%b rv=%b sel=%b want 0/0/0/%b", busy, term_ready, result_valid, sel, S_HOLD); end
    n_tests++; if (y_diag !== '0 || y_new !== '0 || y_old !== '0 || result_out !== '0) begin n_fail++; $display("FAIL abort_data: got %h %h %h %h want all 0", y_diag, y_new, y_old, result_out); end
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (result_valid) rv_cnt++;
    end
    n_tests++; if (rv_cnt !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_quiet: got rv_count=%0d busy=%b want 0/0", rv_cnt, busy); end
    start = 1; num_terms = 0; diag_in = 48'h7;
    tick();
    start = 0;
    tick();
    n_tests++; if (sel !== S_DIAG) begin n_fail++; $display("FAIL abort_sel: got %b want %b", sel, S_DIAG); end
    tick(); tick();
    n_tests++; if (result_valid !== 1'b1 || result_out !== 48'h7) begin n_fail++; $display("FAIL abort_fresh: got rv=%b out=%h want 1/7", result_valid, result_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_terms();
    test_back_to_back();
    test_stall();
    test_start_ignored();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
